// File: rtl/eth_rx_pkg.sv
// Shared constants and types for the RMII receive path: CRC-32 parameters,
// frame-length defaults and the frame-check state encoding.
package eth_rx_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam int DEF_MIN_LEN = 64;
    localparam int DEF_MAX_LEN = 1518;
    localparam int LEN_W       = 11;
    // Bytes parked behind the output register; together with it they hide the 4-byte FCS.
    localparam int LINE_D      = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        DROP   = 3'd3,
        END    = 3'd4
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte update of a reflected CRC-32 register (LSB-first bit order).
module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    // Eight unrolled shift/xor steps of the serial LFSR.
    always_comb begin
        crc_out = crc_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/rmii_rx_frame_check.sv
// Drains the RX byte FIFO, checks CRC-32 and length, strips the FCS and forwards
// the payload as a valid/ready byte stream with a per-frame error flag on the last byte.
module rmii_rx_frame_check
    import eth_rx_pkg::*;
#(
    parameter int MIN_LEN = DEF_MIN_LEN,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = 16
) (
    input  logic             REF_CLK,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_dout,
    input  logic             fifo_EOD_out,
    output logic             fifo_rden,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             m_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    rx_state_e        state_r;
    logic [7:0]       line_r [LINE_D];
    logic [2:0]       fill_r;
    logic [31:0]      crc_r;
    logic [31:0]      crc_next_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_next_s;
    logic             end_bad_r;
    logic             pop_s;
    logic             frame_bad_s;

    crc32_d8 u_crc (
        .crc_in  (crc_r),
        .d       (fifo_dout),
        .crc_out (crc_next_s)
    );

    // Pop when a byte is present and the output register is free or being drained.
    always_comb begin
        pop_s = 1'b0;
        if (!rst && !fifo_empty && (state_r != END) && (!m_valid || m_ready)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Length after this pop (saturating) and the end-of-frame verdict it implies.
    always_comb begin
        len_next_s  = len_r;
        frame_bad_s = 1'b0;
        if (len_r == {LEN_W{1'b1}}) begin
            len_next_s = len_r;
        end else begin
            len_next_s = len_r + LEN_W'(1);
        end
        frame_bad_s = (crc_next_s != CRC_RESIDUE) || (32'(len_next_s) < MIN_LEN);
    end

    assign fifo_rden = pop_s;

    // Frame FSM with delay line, CRC/length tracking, output register and counters.
    always_ff @(posedge REF_CLK) begin
        if (rst) begin
            state_r   <= IDLE;
            fill_r    <= 3'd0;
            crc_r     <= CRC_INIT;
            len_r     <= '0;
            end_bad_r <= 1'b0;
            for (int i = 0; i < LINE_D; i++) begin
                line_r[i] <= 8'd0;
            end
            m_data    <= 8'd0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_err     <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                m_err   <= 1'b0;
            end
            if (pop_s) begin
                crc_r <= crc_next_s;
                len_r <= len_next_s;
            end
            case (state_r)
                IDLE, FILL: begin
                    if (pop_s) begin
                        line_r[0] <= fifo_dout;
                        for (int i = 1; i < LINE_D; i++) begin
                            line_r[i] <= line_r[i-1];
                        end
                        fill_r <= fill_r + 3'd1;
                        if (fifo_EOD_out) begin
                            end_bad_r <= 1'b1;
                            state_r   <= END;
                        end else if (fill_r == 3'(LINE_D - 1)) begin
                            state_r <= STREAM;
                        end else begin
                            state_r <= FILL;
                        end
                    end
                end
                STREAM: begin
                    if (pop_s) begin
                        line_r[0] <= fifo_dout;
                        for (int i = 1; i < LINE_D; i++) begin
                            line_r[i] <= line_r[i-1];
                        end
                        m_data  <= line_r[LINE_D-1];
                        m_valid <= 1'b1;
                        if (fifo_EOD_out) begin
                            m_last    <= 1'b1;
                            m_err     <= frame_bad_s;
                            end_bad_r <= frame_bad_s;
                            state_r   <= END;
                        end else begin
                            m_last <= 1'b0;
                            m_err  <= 1'b0;
                            if (32'(len_next_s) >= MAX_LEN) begin
                                state_r <= DROP;
                            end
                        end
                    end
                end
                DROP: begin
                    // The line is frozen; its oldest byte becomes the error-tagged last byte.
                    if (pop_s && fifo_EOD_out) begin
                        m_data    <= line_r[LINE_D-1];
                        m_valid   <= 1'b1;
                        m_last    <= 1'b1;
                        m_err     <= 1'b1;
                        end_bad_r <= 1'b1;
                        state_r   <= END;
                    end
                end
                END: begin
                    for (int i = 0; i < LINE_D; i++) begin
                        line_r[i] <= 8'd0;
                    end
                    fill_r    <= 3'd0;
                    crc_r     <= CRC_INIT;
                    len_r     <= '0;
                    end_bad_r <= 1'b0;
                    if (end_bad_r) begin
                        if (bad_cnt != {CNT_W{1'b1}}) begin
                            bad_cnt <= bad_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (good_cnt != {CNT_W{1'b1}}) begin
                            good_cnt <= good_cnt + CNT_W'(1);
                        end
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_frame_check.sv
// Directed bench for rmii_rx_frame_check: FWFT FIFO model on the input side,
// transfer recorder on the output side, and a second instance with MIN_LEN=64.
`timescale 1ns/1ps
module tb_rmii_rx_frame_check;

    logic        REF_CLK = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_EOD_out;
    logic        fifo_rden, fifo_rden2;
    logic [7:0]  m_data, m_data2;
    logic        m_valid, m_valid2;
    logic        m_ready = 1'b1;
    logic        m_last, m_last2;
    logic        m_err, m_err2;
    logic [15:0] good_cnt, bad_cnt, good_cnt2, bad_cnt2;

    logic        ready_toggle = 1'b0;
    logic [8:0]  fifo_mem [0:4095];
    logic [11:0] wr_ptr = 12'd0;
    logic [11:0] rd_ptr = 12'd0;
    logic [10:0] rx_mem [0:2047];
    int          rx_cnt = 0;
    int          valid_cycles = 0;
    logic        dut_diff = 1'b0;

    logic [7:0]  g_exp [0:2047];
    logic [7:0]  good64 [0:63];
    logic [7:0]  big [0:1599];
    int          vectors = 0;
    int          miscompares = 0;

    rmii_rx_frame_check #(.MIN_LEN(0), .MAX_LEN(1518), .CNT_W(16)) dut (
        .REF_CLK(REF_CLK), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_EOD_out(fifo_EOD_out), .fifo_rden(fifo_rden), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_err(m_err),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    rmii_rx_frame_check #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut_min (
        .REF_CLK(REF_CLK), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_EOD_out(fifo_EOD_out), .fifo_rden(fifo_rden2), .m_data(m_data2),
        .m_valid(m_valid2), .m_ready(m_ready), .m_last(m_last2), .m_err(m_err2),
        .good_cnt(good_cnt2), .bad_cnt(bad_cnt2)
    );

    always #10 REF_CLK = ~REF_CLK;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_dout    = fifo_mem[rd_ptr][7:0];
    assign fifo_EOD_out = fifo_mem[rd_ptr][8];

    always @(posedge REF_CLK) begin
        if (fifo_rden === 1'b1) rd_ptr <= rd_ptr + 12'd1;
    end

    always @(negedge REF_CLK) begin
        m_ready <= ready_toggle ? ~m_ready : 1'b1;
    end

    always @(posedge REF_CLK) begin
        if (m_valid === 1'b1) valid_cycles <= valid_cycles + 1;
        if (m_valid === 1'b1 && m_ready === 1'b1 && rst === 1'b0 && rx_cnt < 2048) begin
            rx_mem[rx_cnt[10:0]] <= {m_err2, m_err, m_last, m_data};
            rx_cnt <= rx_cnt + 1;
        end
        if ({fifo_rden2, m_valid2, m_last2, m_data2} !== {fifo_rden, m_valid, m_last, m_data}) begin
            dut_diff <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic eod);
        fifo_mem[wr_ptr] = {eod, b};
        wr_ptr = wr_ptr + 12'd1;
    endtask

    task automatic drain();
        int n = 0;
        while (rd_ptr != wr_ptr && n < 5000) begin
            @(negedge REF_CLK);
            n++;
        end
        check("fifo drained", 32'(rd_ptr == wr_ptr), 32'd1);
        repeat (12) @(negedge REF_CLK);
    endtask

    // "123456789" with its FCS; b5 replaces the fifth byte.
    task automatic push_t1(input logic [7:0] b5);
        for (int i = 0; i < 9; i++) begin
            g_exp[i] = (i == 4) ? b5 : 8'(8'h31 + i);
            push(g_exp[i], 1'b0);
        end
        push(8'h26, 1'b0);
        push(8'h39, 1'b0);
        push(8'hF4, 1'b0);
        push(8'hCB, 1'b1);
    endtask

    task automatic push_good(input int first, input int count);
        for (int i = first; i < first + count; i++) push(good64[i], 1'(i == 63));
    endtask

    task automatic check_rx(input string tag, input int base, input int n,
                            input logic err, input logic err_min);
        int got = rx_cnt - base;
        check({tag, " count"}, 32'(got), 32'(n));
        for (int i = 0; i < n && i < got; i++) begin
            logic [10:0] e;
            e = rx_mem[base + i];
            check($sformatf("%s data[%0d]", tag, i), 32'(e[7:0]), 32'(g_exp[i]));
            check($sformatf("%s last[%0d]", tag, i), 32'(e[8]), 32'(i == n - 1));
            if (i == n - 1) begin
                check({tag, " m_err"}, 32'(e[9]), 32'(err));
                check({tag, " m_err min64"}, 32'(e[10]), 32'(err_min));
            end
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    initial begin
        int base;
        int vc;
        logic [31:0] crc;
        logic [31:0] fcs;

        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            good64[i] = 8'(i * 7 + 3);
            crc = crc_upd(crc, good64[i]);
        end
        fcs = ~crc;
        good64[60] = fcs[7:0];
        good64[61] = fcs[15:8];
        good64[62] = fcs[23:16];
        good64[63] = fcs[31:24];
        for (int i = 0; i < 1600; i++) big[i] = 8'(i * 13 + (i >> 8));

        repeat (3) @(negedge REF_CLK);
        check("reset fifo_rden", 32'(fifo_rden), 32'd0);
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset m_last", 32'(m_last), 32'd0);
        check("reset m_err", 32'(m_err), 32'd0);
        check("reset m_data", 32'(m_data), 32'd0);
        check("reset good_cnt", 32'(good_cnt), 32'd0);
        check("reset bad_cnt", 32'(bad_cnt), 32'd0);
        rst = 1'b0;
        @(negedge REF_CLK);

        // Good "123456789" frame
        base = rx_cnt;
        push_t1(8'h35);
        drain();
        check_rx("t1", base, 9, 1'b0, 1'b1);
        check("t1 good_cnt", 32'(good_cnt), 32'd1);
        check("t1 bad_cnt", 32'(bad_cnt), 32'd0);

        // Corrupted fifth byte
        base = rx_cnt;
        push_t1(8'h34);
        drain();
        check_rx("t2", base, 9, 1'b1, 1'b1);
        check("t2 bad_cnt", 32'(bad_cnt), 32'd1);

        // 64-byte good frame under back-pressure
        base = rx_cnt;
        ready_toggle = 1'b1;
        push_good(0, 64);
        drain();
        ready_toggle = 1'b0;
        repeat (4) @(negedge REF_CLK);
        for (int i = 0; i < 60; i++) g_exp[i] = good64[i];
        check_rx("t3", base, 60, 1'b0, 1'b0);
        check("t3 good_cnt", 32'(good_cnt), 32'd2);

        // 3-byte runt, then a clean frame
        vc = valid_cycles;
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b1);
        drain();
        check("t4 runt no m_valid", 32'(valid_cycles - vc), 32'd0);
        check("t4 bad_cnt", 32'(bad_cnt), 32'd2);
        check("t4 good_cnt", 32'(good_cnt), 32'd2);
        base = rx_cnt;
        push_t1(8'h35);
        drain();
        check_rx("t4 next", base, 9, 1'b0, 1'b1);
        check("t4 next good_cnt", 32'(good_cnt), 32'd3);

        // Oversize 1600-byte frame
        base = rx_cnt;
        for (int i = 0; i < 1600; i++) push(big[i], 1'(i == 1599));
        drain();
        for (int i = 0; i < 1515; i++) g_exp[i] = big[i];
        check_rx("t5", base, 1515, 1'b1, 1'b1);
        check("t5 bad_cnt", 32'(bad_cnt), 32'd3);
        check("t5 min64 good_cnt", 32'(good_cnt2), 32'd1);
        check("t5 min64 bad_cnt", 32'(bad_cnt2), 32'd5);

        // Reset after 20 bytes of a good frame; the tail is a new, failing frame
        push_good(0, 20);
        drain();
        rst = 1'b1;
        @(negedge REF_CLK);
        check("t6 rst m_valid", 32'(m_valid), 32'd0);
        check("t6 rst m_last", 32'(m_last), 32'd0);
        check("t6 rst m_err", 32'(m_err), 32'd0);
        check("t6 rst m_data", 32'(m_data), 32'd0);
        check("t6 rst good_cnt", 32'(good_cnt), 32'd0);
        check("t6 rst bad_cnt", 32'(bad_cnt), 32'd0);
        rst = 1'b0;
        @(negedge REF_CLK);
        base = rx_cnt;
        push_good(20, 44);
        drain();
        for (int i = 0; i < 40; i++) g_exp[i] = good64[20 + i];
        check_rx("t6 tail", base, 40, 1'b1, 1'b1);
        check("t6 tail bad_cnt", 32'(bad_cnt), 32'd1);
        base = rx_cnt;
        push_good(0, 64);
        drain();
        for (int i = 0; i < 60; i++) g_exp[i] = good64[i];
        check_rx("t6 good", base, 60, 1'b0, 1'b0);
        check("t6 good_cnt", 32'(good_cnt), 32'd1);
        check("t6 final bad_cnt", 32'(bad_cnt), 32'd1);

        check("instances agree on stream", 32'(dut_diff), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
